spi_target: RTL and testbench

//  SPI mode-0 target (slave) port: the responding end of the bit-banged SPI the j1 drives on PIOS.
//  An external SPI controller can exchange bytes with the j1 through an IO slot.

---
 rtl/spi_target_if.sv | 32 +++
 rtl/spi_target.sv | 200 ++++++++++++++++++++
 tb/tb_spi_target.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_target_if.sv
// SPI pins plus the byte-level register interface of the SPI target port.
// Pure wiring; no latency of its own.
// Backpressure: none; the host side uses tx_free / valid / overrun status bits.
interface spi_target_if;
  // SPI pins (controller side)
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  // byte interface (host side)
  logic       wr;
  logic [7:0] tx_data;
  logic       tx_free;
  logic       rd;
  logic [7:0] rx_data;
  logic       valid;
  logic       overrun;
  logic       active;

  // the target port itself
  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, wr, tx_data, rd,
    output spi_miso, spi_miso_oe, tx_free, rx_data, valid, overrun, active
  );

  // the environment driving the target: SPI controller plus host
  modport master (
    output spi_sck, spi_cs_n, spi_mosi, wr, tx_data, rd,
    input  spi_miso, spi_miso_oe, tx_free, rx_data, valid, overrun, active
  );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target with oversampled SCK/CS_N/MOSI and a one-byte tx holding register.
// Latency: valid rises SYNC_STAGES+1 clk after the 8th SCK rise reaches the synchroniser.
// Backpressure: none; an unread rx byte causes the next byte to be dropped and overrun set.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic         clk,
  input  logic         resetq,
  spi_target_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEL  = 1'b1
  } state_t;

  // synchroniser chains; index SYNC_STAGES-1 is the stage used by the logic
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  // one extra delay on sck and cs_n for edge detection
  logic                   sck_dly_q, sck_dly_d;
  logic                   cs_dly_q, cs_dly_d;

  state_t                 state_q, state_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [6:0]             shift_rx_q, shift_rx_d;   // first 7 bits of the byte in flight
  logic [6:0]             shift_tx_q, shift_tx_d;   // bits still to go after the one on miso
  logic                   skip_fall_q, skip_fall_d; // next sck fall follows a reload
  logic                   miso_q, miso_d;           // bit currently presented on MISO
  logic [7:0]             hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic                   sck_s, cs_n_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;
  logic                   byte_done;
  logic [7:0]             reload_val;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_n_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_dly_q;
  assign sck_fall = ~sck_s & sck_dly_q;
  assign cs_fall  = ~cs_n_s & cs_dly_q;
  assign cs_rise  = cs_n_s & ~cs_dly_q;

  // the byte that goes out next: the held byte if there is one, else the idle filler
  assign reload_val = hold_full_q ? hold_q : IDLE_BYTE;

  // synchroniser shift and edge-detect delay
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
    sck_dly_d   = sck_s;
    cs_dly_d    = cs_n_s;
  end

  // synchroniser registers; idle levels are sck low, cs_n high
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_dly_q   <= sck_dly_d;
      cs_dly_q    <= cs_dly_d;
    end
  end

  // select FSM, shift registers, tx holding register and rx status
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_rx_d  = shift_rx_q;
    shift_tx_d  = shift_tx_q;
    skip_fall_d = skip_fall_q;
    miso_d      = miso_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    byte_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // sck edges coinciding with the select edge are deliberately ignored
        if (cs_fall) begin
          state_d     = ST_SEL;
          bitcnt_d    = 3'd0;
          miso_d      = reload_val[7];
          shift_tx_d  = reload_val[6:0];
          hold_full_d = 1'b0;
          skip_fall_d = 1'b0;
        end
      end
      ST_SEL: begin
        if (cs_rise) begin
          // deselect drops any partial byte; rx status and holding survive
          state_d     = ST_IDLE;
          bitcnt_d    = 3'd0;
          miso_d      = 1'b1;
          skip_fall_d = 1'b0;
        end else if (sck_rise) begin
          shift_rx_d = {shift_rx_q[5:0], mosi_s};
          bitcnt_d   = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            // byte boundary: next byte's MSB must be on MISO before the next rise
            byte_done   = 1'b1;
            miso_d      = reload_val[7];
            shift_tx_d  = reload_val[6:0];
            hold_full_d = 1'b0;
            skip_fall_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (skip_fall_q) begin
            // MSB was already presented by the reload
            skip_fall_d = 1'b0;
          end else begin
            miso_d     = shift_tx_q[6];
            shift_tx_d = {shift_tx_q[5:0], 1'b0};
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.rd) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    // an rd in the completing cycle frees the slot for the new byte
    if (byte_done) begin
      if (!valid_q || bus.rd) begin
        rx_data_d = {shift_rx_q, mosi_s};
        valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // a write lands after any reload in the same cycle, so the reload sees the old byte
    if (bus.wr) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 3'd0;
      shift_rx_q  <= 7'd0;
      shift_tx_q  <= 7'd0;
      skip_fall_q <= 1'b0;
      miso_q      <= 1'b1;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      rx_data_q   <= 8'd0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_rx_q  <= shift_rx_d;
      shift_tx_q  <= shift_tx_d;
      skip_fall_q <= skip_fall_d;
      miso_q      <= miso_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = (state_q == ST_SEL);
  assign bus.active      = (state_q == ST_SEL);
  assign bus.tx_free     = ~hold_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.valid       = valid_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a vector table of single-byte sessions plus
// hand-written multi-byte, partial-byte, reload-race and mid-transfer reset sequences.
// SCK runs at clk/8 (4 clk high, 4 clk low); inputs change on the falling clk edge.
module tb_spi_target;

  logic clk = 1'b0;
  logic resetq = 1'b0;

  spi_target_if bus ();

  spi_target #(
    .SYNC_STAGES (2),
    .IDLE_BYTE   (8'hFF)
  ) dut (
    .clk    (clk),
    .resetq (resetq),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       do_wr;
    logic [7:0] wr_byte;
    logic [7:0] mosi;
    logic       rd_after;
    logic       chk_lat;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    logic       exp_valid;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs [5];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_wr(input logic [7:0] d);
    bus.tx_data = d;
    bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  task automatic pulse_rd();
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic cs_select();
    bus.spi_cs_n = 1'b0;
    clks(4);
  endtask

  task automatic cs_release();
    clks(4);
    bus.spi_cs_n = 1'b1;
    clks(6);
  endtask

  // one SPI bit: MOSI set and MISO sampled during the low phase, then a high phase
  task automatic spi_bit(input logic b, output logic mi);
    bus.spi_mosi = b;
    clks(4);
    mi = bus.spi_miso;
    bus.spi_sck = 1'b1;
    clks(4);
    bus.spi_sck = 1'b0;
  endtask

  // one SPI byte. rd_at/wr_at: clk index within the 8th high phase to pulse rd/wr
  // (-1 none). wr_bit: bit index during whose low phase wmid is written (-1 none).
  // lat: clk count from the 8th rise until valid is seen (99 if not within the phase).
  task automatic spi_byte(input logic [7:0] mo, input int rd_at, input int wr_at,
                          input logic [7:0] wd, input int wr_bit, input logic [7:0] wmid,
                          output logic [7:0] mi, output int lat);
    lat = 99;
    for (int i = 7; i >= 0; i--) begin
      bus.spi_mosi = mo[i];
      if (i == wr_bit) begin
        pulse_wr(wmid);
        clks(3);
      end else begin
        clks(4);
      end
      mi[i] = bus.spi_miso;
      bus.spi_sck = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (i == 0) begin
          bus.rd = (j == rd_at);
          bus.wr = (j == wr_at);
          if (j == wr_at) bus.tx_data = wd;
        end
        @(negedge clk);
        if (i == 0 && lat == 99 && bus.valid) lat = j + 1;
      end
      bus.rd = 1'b0;
      bus.wr = 1'b0;
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_miso"},    bus.spi_miso,    1'b1);
    chk1({tag, "_oe"},      bus.spi_miso_oe, 1'b0);
    chk1({tag, "_tx_free"}, bus.tx_free,     1'b1);
    chk8({tag, "_rx_data"}, bus.rx_data,     8'h00);
    chk1({tag, "_valid"},   bus.valid,       1'b0);
    chk1({tag, "_overrun"}, bus.overrun,     1'b0);
    chk1({tag, "_active"},  bus.active,      1'b0);
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] nib;
    logic       b;
    int         lat;

    //                do_wr wr_byte mosi   rd_aft chk_lat exp_miso exp_rx valid ovr
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 8'h12, 1'b1, 1'b1, 8'hFF, 8'h12, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 8'h07, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 8'h01, 1'b1, 1'b0};

    bus.spi_sck  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.wr       = 1'b0;
    bus.rd       = 1'b0;
    bus.tx_data  = 8'h00;

    // ---- reset held with inputs toggling
    resetq = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.spi_sck  = k[0];
      bus.spi_cs_n = k[1];
      bus.spi_mosi = ~k[0];
      bus.wr       = k[0];
      bus.tx_data  = 8'h5A;
      bus.rd       = k[1];
      @(negedge clk);
      if (k == 3) chk_reset_outputs("rst_toggle_mid");
    end
    chk_reset_outputs("rst_toggle_end");
    bus.spi_sck  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.wr       = 1'b0;
    bus.rd       = 1'b0;
    clks(2);
    resetq = 1'b1;
    clks(4);
    chk_reset_outputs("after_release");

    // ---- table of single-byte sessions
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].do_wr) begin
        pulse_wr(vecs[v].wr_byte);
        chk1("tbl_tx_free_after_wr", bus.tx_free, 1'b0);
      end
      cs_select();
      chk1("tbl_active_sel", bus.active, 1'b1);
      chk1("tbl_oe_sel", bus.spi_miso_oe, 1'b1);
      chk1("tbl_tx_free_sel", bus.tx_free, 1'b1);
      spi_byte(vecs[v].mosi, -1, -1, 8'h00, -1, 8'h00, mi, lat);
      chk8("tbl_miso_byte", mi, vecs[v].exp_miso);
      if (vecs[v].chk_lat) chk1("tbl_valid_within_4clk", (lat >= 1 && lat <= 4), 1'b1);
      cs_release();
      chk1("tbl_oe_desel", bus.spi_miso_oe, 1'b0);
      chk1("tbl_active_desel", bus.active, 1'b0);
      chk1("tbl_miso_desel", bus.spi_miso, 1'b1);
      chk8("tbl_rx_data", bus.rx_data, vecs[v].exp_rx);
      chk1("tbl_valid", bus.valid, vecs[v].exp_valid);
      chk1("tbl_overrun", bus.overrun, vecs[v].exp_ovr);
      if (vecs[v].rd_after) begin
        pulse_rd();
        chk1("tbl_valid_after_rd", bus.valid, 1'b0);
        chk1("tbl_overrun_after_rd", bus.overrun, 1'b0);
      end
    end

    // ---- two bytes in one session with rd after each, no tx byte held
    cs_select();
    spi_byte(8'h12, -1, -1, 8'h00, -1, 8'h00, mi, lat);
    chk8("two_miso1", mi, 8'hFF);
    chk8("two_rx1", bus.rx_data, 8'h12);
    pulse_rd();
    chk1("two_valid_cleared", bus.valid, 1'b0);
    spi_byte(8'h34, -1, -1, 8'h00, -1, 8'h00, mi, lat);
    chk8("two_miso2", mi, 8'hFF);
    chk8("two_rx2", bus.rx_data, 8'h34);
    chk1("two_valid2", bus.valid, 1'b1);
    chk1("two_overrun", bus.overrun, 1'b0);
    cs_release();
    pulse_rd();

    // ---- overrun: 0x55 then 0xAA unread
    cs_select();
    spi_byte(8'h55, -1, -1, 8'h00, -1, 8'h00, mi, lat);
    spi_byte(8'hAA, -1, -1, 8'h00, -1, 8'h00, mi, lat);
    chk8("ovr_rx_kept", bus.rx_data, 8'h55);
    chk1("ovr_flag", bus.overrun, 1'b1);
    chk1("ovr_valid", bus.valid, 1'b1);
    pulse_rd();
    chk1("ovr_rd_valid", bus.valid, 1'b0);
    chk1("ovr_rd_flag", bus.overrun, 1'b0);
    cs_release();

    // ---- rd in the cycle the second byte completes
    cs_select();
    spi_byte(8'h55, -1, -1, 8'h00, -1, 8'h00, mi, lat);
    spi_byte(8'hAA, 2, -1, 8'h00, -1, 8'h00, mi, lat);
    chk8("rdsame_rx", bus.rx_data, 8'hAA);
    chk1("rdsame_valid", bus.valid, 1'b1);
    chk1("rdsame_overrun", bus.overrun, 1'b0);
    cs_release();
    pulse_rd();

    // ---- partial byte (5 bits of 0xF0) dropped by deselect, then 0x81
    cs_select();
    for (int k = 7; k >= 3; k--) begin
      nib = 8'hF0;
      spi_bit(nib[k], b);
    end
    cs_release();
    chk1("partial_no_valid", bus.valid, 1'b0);
    chk8("partial_rx_kept", bus.rx_data, 8'hAA);
    cs_select();
    spi_byte(8'h81, -1, -1, 8'h00, -1, 8'h00, mi, lat);
    chk8("after_partial_rx", bus.rx_data, 8'h81);
    chk1("after_partial_valid", bus.valid, 1'b1);
    cs_release();
    pulse_rd();

    // ---- wr mid byte 1, wr in reload cycle, then reset mid byte 3
    cs_select();
    spi_byte(8'h5C, -1, 2, 8'h22, 4, 8'h11, mi, lat);
    chk8("race_miso1", mi, 8'hFF);
    chk1("race_tx_free_held", bus.tx_free, 1'b0);
    spi_byte(8'h00, -1, -1, 8'h00, -1, 8'h00, mi, lat);
    chk8("race_miso2", mi, 8'h11);
    chk1("race_tx_free_after2", bus.tx_free, 1'b1);
    chk1("race_overrun", bus.overrun, 1'b1);
    chk8("race_rx", bus.rx_data, 8'h5C);
    nib = 8'h00;
    for (int k = 7; k >= 4; k--) begin
      spi_bit(1'b0, b);
      nib[k] = b;
    end
    chk8("race_miso3_hi_nibble", nib, 8'h20);
    pulse_wr(8'h33);
    chk1("race_tx_free_pre_reset", bus.tx_free, 1'b0);
    resetq = 1'b0;
    #1;
    chk_reset_outputs("midxfer_reset");
    @(negedge clk);
    bus.spi_cs_n = 1'b1;
    clks(2);
    resetq = 1'b1;
    clks(4);
    chk_reset_outputs("post_reset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
